simple_mux_rr: RTL

Parametrised N-channel successor to the team's combinational 4:1 select mux.
- Adds per-channel valid/ready handshakes and one registered output stage.
- Two grant modes: fixed select (sel-driven, same priority semantics as the old mux) and round-robin.
- Sits between multiple producers and a single consumer in the simple datapath.

---
 rtl/simple_mux_rr.sv | 114 +++++++++++
 1 files changed

// File: rtl/simple_mux_rr.sv
// N-channel valid/ready mux with fixed-select or round-robin grant and one registered output stage.
// Optional transfer counter (xfer_cnt, cnt_sat) is built when SIMPLE_MUX_RR_CNT_EN is defined.
module simple_mux_rr #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8,
    parameter int SEL_W  = (NUM_CH > 2) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         sel,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic [NUM_CH-1:0]        in_valid,
    output logic [NUM_CH-1:0]        in_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    output logic [SEL_W-1:0]         out_ch,
`ifdef SIMPLE_MUX_RR_CNT_EN
    output logic [15:0]              xfer_cnt,
    output logic                     cnt_sat,
`endif
    input  logic                     out_ready
);

    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic [SEL_W-1:0]  out_ch_q, out_ch_d;
    logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;

    logic [NUM_CH-1:0] grant;
    logic [SEL_W-1:0]  gnt_idx;
    logic [SEL_W-1:0]  eff_sel;
    logic              gnt_any;
    logic              load;
    logic              xfer;

    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        eff_sel = sel;
        if (!mode) begin
            // out-of-range selects fall to the last channel, like the old mux default branch
            if (int'(sel) >= NUM_CH) eff_sel = SEL_W'(NUM_CH - 1);
            if (in_valid[eff_sel]) begin
                gnt_any = 1'b1;
                gnt_idx = eff_sel;
            end
        end else begin
            for (int k = 1; k <= NUM_CH; k++) begin
                if (!gnt_any && in_valid[SEL_W'((int'(rr_ptr_q) + k) % NUM_CH)]) begin
                    gnt_any = 1'b1;
                    gnt_idx = SEL_W'((int'(rr_ptr_q) + k) % NUM_CH);
                end
            end
        end
        if (gnt_any) grant[gnt_idx] = 1'b1;
    end

    assign load     = !out_valid_q | out_ready;
    assign in_ready = (rst || !load) ? '0 : grant;
    assign xfer     = gnt_any & load & !rst;

    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_ch_d    = out_ch_q;
        rr_ptr_d    = rr_ptr_q;
        if (xfer) begin
            out_data_d  = in_data[int'(gnt_idx)*DATA_W +: DATA_W];
            out_valid_d = 1'b1;
            out_ch_d    = gnt_idx;
            rr_ptr_d    = mode ? gnt_idx : rr_ptr_q;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            rr_ptr_q    <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;

`ifdef SIMPLE_MUX_RR_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (out_valid_q && out_ready && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign xfer_cnt = cnt_q;
    assign cnt_sat  = (cnt_q == 16'hFFFF);
`endif

endmodule
